// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: round-robin arbiter that shares one VGA pixel-write port
// between N_REQ rectangle-fill requesters. The winning rectangle is rasterised
// one pixel per cycle in raster order and clipped to the 160x120 frame.
module vga_draw_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] rect_x,
  input  logic [7*N_REQ-1:0] rect_y,
  input  logic [8*N_REQ-1:0] rect_w,
  input  logic [7*N_REQ-1:0] rect_h,
  input  logic [3*N_REQ-1:0] rect_colour,
  output logic [N_REQ-1:0]   grant,
  output logic               done,
  output logic               busy,
  output logic [7:0]         vga_x,
  output logic [6:0]         vga_y,
  output logic [2:0]         vga_colour,
  output logic               vga_plot
);

  localparam int PW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [PW-1:0] rr_ptr, winner, pick;

  // Latched job and scan position (dx/dy = pixel currently on the port)
  logic [7:0] x0, w, dx, nx;
  logic [6:0] y0, h, dy, ny;
  logic [2:0] col;

  // Winner's live request parameters, only meaningful during LATCH
  logic [7:0] sel_x, sel_w;
  logic [6:0] sel_y, sel_h;
  logic [2:0] sel_col;

  logic       last, emit, plot_ok;
  logic [8:0] ex;
  logic [7:0] ey;
  logic [2:0] ecol;

  // Round-robin pick: first set req at or after rr_ptr, wrapping upward.
  // Scanning from the far end lets the nearest candidate overwrite the rest.
  always_comb begin
    int idx;
    pick = '0;
    idx  = 0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) pick = PW'(idx);
    end
  end

  assign sel_x   = rect_x[8*int'(winner) +: 8];
  assign sel_y   = rect_y[7*int'(winner) +: 7];
  assign sel_w   = rect_w[8*int'(winner) +: 8];
  assign sel_h   = rect_h[7*int'(winner) +: 7];
  assign sel_col = rect_colour[3*int'(winner) +: 3];

  // Raster-order step: dx is the inner loop
  always_comb begin
    last = (dx == w - 8'd1) && (dy == h - 7'd1);
    if (dx == w - 8'd1) begin
      nx = 8'd0;
      ny = dy + 7'd1;
    end else begin
      nx = dx + 8'd1;
      ny = dy;
    end
  end

  // Next state and the pixel to present after this edge. The first pixel is
  // taken straight from the inputs at LATCH so it appears the cycle after.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    ex        = {1'b0, sel_x};
    ey        = {1'b0, sel_y};
    ecol      = sel_col;
    case (state)
      S_IDLE:  if (|req) state_nxt = S_LATCH;
      S_LATCH: begin
        if (sel_w == 8'd0 || sel_h == 7'd0) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_DRAW;
          emit      = 1'b1;
        end
      end
      S_DRAW: begin
        if (last) begin
          state_nxt = S_DONE;
        end else begin
          emit = 1'b1;
          ex   = {1'b0, x0} + {1'b0, nx};
          ey   = {1'b0, y0} + {1'b0, ny};
          ecol = col;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Off-screen pixels still consume their cycle, only the strobe is masked
  assign plot_ok = emit && (ex < 9'd160) && (ey < 8'd120);

  // State, registered outputs and job bookkeeping
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      winner     <= '0;
      grant      <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      x0         <= '0;
      y0         <= '0;
      w          <= '0;
      h          <= '0;
      col        <= '0;
      dx         <= '0;
      dy         <= '0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != S_IDLE);
      done     <= (state_nxt == S_DONE);
      vga_plot <= plot_ok;
      if (plot_ok) begin
        vga_x      <= ex[7:0];
        vga_y      <= ey[6:0];
        vga_colour <= ecol;
      end
      case (state)
        S_IDLE: begin
          if (|req) begin
            winner <= pick;
            grant  <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
          end
        end
        S_LATCH: begin
          x0  <= sel_x;
          y0  <= sel_y;
          w   <= sel_w;
          h   <= sel_h;
          col <= sel_col;
          dx  <= '0;
          dy  <= '0;
        end
        S_DRAW: begin
          if (!last) begin
            dx <= nx;
            dy <= ny;
          end
        end
        default: begin
          grant  <= '0;
          rr_ptr <= (winner == PW'(N_REQ-1)) ? '0 : winner + 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Self-checking bench for vga_draw_arbiter: directed scenarios plus random jobs
// checked cycle by cycle against a behavioural job model.
module tb_vga_draw_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] rect_x = '0;
  logic [7*N-1:0] rect_y = '0;
  logic [8*N-1:0] rect_w = '0;
  logic [7*N-1:0] rect_h = '0;
  logic [3*N-1:0] rect_colour = '0;
  logic [N-1:0]   grant;
  logic           done, busy, vga_plot;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_colour;

  vga_draw_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .resetn(resetn), .req(req),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .rect_colour(rect_colour), .grant(grant), .done(done), .busy(busy),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester parameter table and model state
  int px[N], py[N], pw[N], ph[N], pc[N];
  int m_ptr = 0;
  int lx = 0, ly = 0, lc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      rect_x[8*i +: 8]      = 8'(px[i]);
      rect_y[7*i +: 7]      = 7'(py[i]);
      rect_w[8*i +: 8]      = 8'(pw[i]);
      rect_h[7*i +: 7]      = 7'(ph[i]);
      rect_colour[3*i +: 3] = 3'(pc[i]);
    end
  endtask

  task automatic set_req(input int i, input int x, input int y, input int ww, input int hh, input int c);
    px[i] = x; py[i] = y; pw[i] = ww; ph[i] = hh; pc[i] = c;
  endtask

  // One complete job: raise rq, then check every cycle up to the IDLE after done
  task automatic run_job(input logic [N-1:0] rq, input bit hold);
    int win, x, y, ww, hh, c, idx;
    bit ins;
    logic [N-1:0] oh;
    win = 0;
    for (int k = N-1; k >= 0; k--) begin
      idx = (m_ptr + k) % N;
      if (rq[idx]) win = idx;
    end
    x = px[win]; y = py[win]; ww = pw[win]; hh = ph[win]; c = pc[win];
    oh = '0;
    oh[win] = 1'b1;
    drive();
    req = rq;
    tick();
    chk("latch_grant", grant, oh);
    chk("latch_busy", busy, 1);
    chk("latch_plot", vga_plot, 0);
    chk("latch_done", done, 0);
    if (!hold) req = '0;
    for (int yy = 0; yy < hh; yy++) begin
      for (int xx = 0; xx < ww; xx++) begin
        tick();
        if (yy == 0 && xx == 0) begin
          // parameters are free to change once LATCH is over
          px[win] = $urandom_range(0, 255);
          py[win] = $urandom_range(0, 127);
          pc[win] = (c + 1 + $urandom_range(0, 6)) % 8;
          drive();
        end
        ins = (x + xx < 160) && (y + yy < 120);
        if (ins) begin
          lx = x + xx; ly = y + yy; lc = c;
        end
        chk("draw_plot", vga_plot, ins);
        chk("draw_x", vga_x, lx);
        chk("draw_y", vga_y, ly);
        chk("draw_col", vga_colour, lc);
        chk("draw_grant", grant, oh);
        chk("draw_done", done, 0);
      end
    end
    tick();
    chk("done_pulse", done, 1);
    chk("done_grant", grant, oh);
    chk("done_plot", vga_plot, 0);
    chk("done_busy", busy, 1);
    tick();
    chk("idle_grant", grant, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    m_ptr = (win + 1) % N;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_plot"}, vga_plot, 0);
    chk({tag, "_x"}, vga_x, 0);
    chk({tag, "_y"}, vga_y, 0);
    chk({tag, "_col"}, vga_colour, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_req(i, 0, 0, 1, 1, 0);
    drive();
    // reset state
    tick(); tick(); tick();
    chk_reset_outputs("reset");
    resetn = 1'b1;
    tick();
    chk_reset_outputs("post_reset");

    // round robin with all requesters held, 1x1 jobs
    for (int i = 0; i < N; i++) set_req(i, 5 * i, 3 * i, 1, 1, i + 1);
    for (int j = 0; j < 5; j++) run_job('1, 1);
    req = '0;
    tick();
    chk("rr_quiet", grant, 0);

    // single job from requester 0
    set_req(0, 10, 20, 3, 2, 3'b100);
    run_job(4'b0001, 0);

    // clipping at the bottom-right corner
    set_req(2, 158, 119, 4, 2, 3'b011);
    run_job(4'b0100, 0);

    // empty rectangle
    set_req(1, 40, 40, 0, 5, 3'b111);
    run_job(4'b0010, 0);

    // random jobs, including off-screen and empty ones
    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < N; i++)
        set_req(i, $urandom_range(0, 255), $urandom_range(0, 127),
                $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 7));
      run_job(4'($urandom_range(1, 15)), 0);
    end

    // reset in the middle of a 10x10 draw
    set_req(0, 20, 30, 10, 10, 3'b010);
    set_req(1, 50, 60, 2, 2, 3'b101);
    drive();
    req = 4'b0001;
    tick();
    req = '0;
    for (int k = 0; k < 5; k++) tick();
    chk("mid_plot_live", vga_plot, 1);
    resetn = 1'b0;
    tick();
    chk_reset_outputs("mid_reset");
    tick();
    chk("mid_reset_nodone", done, 0);
    resetn = 1'b1;
    m_ptr = 0; lx = 0; ly = 0; lc = 0;
    set_req(0, 20, 30, 2, 1, 3'b010);
    run_job(4'b0011, 0);
    run_job(4'b0010, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
